// File: rtl/sensor_model_pkg.sv
// Shared definitions for the sensor noise filter: FSM encoding,
// pipeline latency and channel-slicing helpers.
package sensor_model_pkg;

    // Frame-tracking states. WAIT_IDLE holds outputs at zero until a clean
    // frame boundary is seen, so a partial frame is never re-emitted.
    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        ARMED     = 2'd1,
        ACTIVE    = 2'd2
    } filt_state_t;

    // Input beat t appears on the output bus at t + FILTER_LATENCY.
    localparam int FILTER_LATENCY = 2;

    // Default bus geometry.
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_CHANNEL_NUM = 4;

    // LSB position of channel ch inside a packed multi-channel beat.
    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/sensor_noise_filter_detect.sv
// Per-channel impulse detector: compares the centre pixel against its left
// and right neighbours and substitutes their mean for an isolated spike.
module impulse_detect_ch #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] iv_left,
    input  logic [DATA_WIDTH-1:0] iv_center,
    input  logic [DATA_WIDTH-1:0] iv_right,
    input  logic [DATA_WIDTH-1:0] iv_threshold,
    input  logic                  i_en,
    input  logic                  i_nb_valid,
    output logic [DATA_WIDTH-1:0] ov_pix,
    output logic                  o_corrected
);

    // One extra bit so C+T and L+R never wrap.
    logic [DATA_WIDTH:0]   w_l;
    logic [DATA_WIDTH:0]   w_c;
    logic [DATA_WIDTH:0]   w_r;
    logic [DATA_WIDTH:0]   w_t;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_avg;
    logic                  w_high;
    logic                  w_low;

    assign w_l = {1'b0, iv_left};
    assign w_c = {1'b0, iv_center};
    assign w_r = {1'b0, iv_right};
    assign w_t = {1'b0, iv_threshold};

    // Strict comparisons: a deviation equal to the threshold is not a spike.
    assign w_high = (w_c > w_l + w_t) && (w_c > w_r + w_t);
    assign w_low  = (w_c + w_t < w_l) && (w_c + w_t < w_r);

    assign w_sum = w_l + w_r;
    assign w_avg = DATA_WIDTH'(w_sum >> 1);

    assign o_corrected = (w_high || w_low) && i_en && i_nb_valid;
    assign ov_pix      = o_corrected ? w_avg : iv_center;

endmodule

// File: rtl/sensor_noise_filter.sv
// Impulse-noise filter for the fval/lval/pixel sensor bus.
// A 3-tap horizontal window (left = s2, centre = s1, right = live input)
// corrects isolated spikes per channel; the bus is re-emitted 2 cycles late.
// Optional build macro NOISE_FILTER_STAT_EN adds the per-frame correction
// counter (ov_noise_cnt / o_cnt_valid); without it both are tied to 0.
module sensor_noise_filter
    import sensor_model_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNEL_NUM = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_filter_en,
    input  logic [DATA_WIDTH-1:0]             iv_threshold,
    input  logic                              i_fval,
    input  logic                              i_lval,
    input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
    output logic                              o_fval,
    output logic                              o_lval,
    output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
    output logic [CNT_WIDTH-1:0]              ov_noise_cnt,
    output logic                              o_cnt_valid
);

    localparam int PIX_W = DATA_WIDTH * CHANNEL_NUM;

    filt_state_t              r_state;
    filt_state_t              w_next_state;
    logic                     w_beat_en;

    logic [PIX_W-1:0]         r_s1_pix;
    logic                     r_s1_lval;
    logic                     r_s1_fval;
    logic                     r_s1_en;
    logic [PIX_W-1:0]         r_s2_pix;
    logic                     r_s2_lval;

    logic                     w_nb_valid;
    logic [PIX_W-1:0]         w_filt_pix;
    logic [CHANNEL_NUM-1:0]   w_corr;

    logic                     r_o_fval;
    logic                     r_o_lval;
    logic [PIX_W-1:0]         r_o_pix;
    logic                     w_out_fval_next;

    // Frame-tracking state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= WAIT_IDLE;
        else       r_state <= w_next_state;
    end

    // Next state: wait for a frame gap, then follow fval in and out.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT_IDLE: if (!i_fval) w_next_state = ARMED;
            ARMED:     if (i_fval)  w_next_state = ACTIVE;
            ACTIVE:    if (!i_fval) w_next_state = ARMED;
            default:   w_next_state = WAIT_IDLE;
        endcase
    end

    // A beat is emitted only if it arrived outside WAIT_IDLE; the flag
    // travels with the beat so gating lines up with the delayed bus.
    assign w_beat_en = (r_state != WAIT_IDLE);

    // Two-deep beat history; each stage keeps its own lval.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_pix  <= '0;
            r_s1_lval <= 1'b0;
            r_s1_fval <= 1'b0;
            r_s1_en   <= 1'b0;
            r_s2_pix  <= '0;
            r_s2_lval <= 1'b0;
        end else begin
            r_s1_pix  <= iv_pix_data;
            r_s1_lval <= i_lval;
            r_s1_fval <= i_fval;
            r_s1_en   <= w_beat_en;
            r_s2_pix  <= r_s1_pix;
            r_s2_lval <= r_s1_lval;
        end
    end

    // Both neighbours must belong to the same line as the centre.
    assign w_nb_valid = (r_s2_lval && r_s1_lval) && (i_lval && r_s1_lval);

    for (genvar k = 0; k < CHANNEL_NUM; k++) begin : g_ch
        impulse_detect_ch #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_detect (
            .iv_left      (r_s2_pix[ch_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
            .iv_center    (r_s1_pix[ch_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
            .iv_right     (iv_pix_data[ch_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
            .iv_threshold (iv_threshold),
            .i_en         (i_filter_en),
            .i_nb_valid   (w_nb_valid),
            .ov_pix       (w_filt_pix[ch_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
            .o_corrected  (w_corr[k])
        );
    end

    assign w_out_fval_next = r_s1_fval && r_s1_en;

    // Output register: filtered centre beat plus gated, delayed fval/lval.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_o_fval <= 1'b0;
            r_o_lval <= 1'b0;
            r_o_pix  <= '0;
        end else begin
            r_o_fval <= w_out_fval_next;
            r_o_lval <= r_s1_lval && r_s1_en;
            r_o_pix  <= r_s1_en ? w_filt_pix : '0;
        end
    end

    assign o_fval      = r_o_fval;
    assign o_lval      = r_o_lval;
    assign ov_pix_data = r_o_pix;

`ifdef NOISE_FILTER_STAT_EN
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_noise_cnt;
    logic                 r_cnt_valid;
    // One spare bit holds the carry of a single beat's additions.
    logic [CNT_WIDTH:0]   w_corr_num;
    logic [CNT_WIDTH:0]   w_cnt_sum;
    logic                 w_frame_end;

    // Number of channels corrected in the beat entering the output register.
    always_comb begin
        w_corr_num = '0;
        for (int k = 0; k < CHANNEL_NUM; k++) begin
            w_corr_num = w_corr_num + (CNT_WIDTH + 1)'(w_corr[k]);
        end
    end

    assign w_cnt_sum   = {1'b0, r_cnt} + w_corr_num;
    assign w_frame_end = r_o_fval && !w_out_fval_next;

    // Saturating per-frame counter; published and cleared at frame end.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_noise_cnt <= '0;
            r_cnt_valid <= 1'b0;
        end else begin
            r_cnt_valid <= 1'b0;
            if (w_frame_end) begin
                r_noise_cnt <= r_cnt;
                r_cnt_valid <= 1'b1;
                r_cnt       <= '0;
            end else if (w_out_fval_next) begin
                r_cnt <= w_cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : w_cnt_sum[CNT_WIDTH-1:0];
            end
        end
    end

    assign ov_noise_cnt = r_noise_cnt;
    assign o_cnt_valid  = r_cnt_valid;
`else
    logic w_unused_corr;
    assign w_unused_corr = ^w_corr;
    assign ov_noise_cnt  = '0;
    assign o_cnt_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_noise_filter.sv
// Self-checking bench for sensor_noise_filter: directed frames, expected
// beats and frame counts queued at drive time, popped by a monitor.
module tb_sensor_noise_filter;

    localparam int DW = 8;
    localparam int CH = 4;
    localparam int CW = 4;
    localparam int PW = DW * CH;
    localparam int W  = 1 + PW;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_filter_en;
    logic [DW-1:0] iv_threshold;
    logic          i_fval;
    logic          i_lval;
    logic [PW-1:0] iv_pix_data;
    logic          o_fval;
    logic          o_lval;
    logic [PW-1:0] ov_pix_data;
    logic [CW-1:0] ov_noise_cnt;
    logic          o_cnt_valid;

    logic [W-1:0]  exp_q[$];
    int            exp_cyc_q[$];
    logic [CW-1:0] cnt_q[$];
    int            cnt_cyc_q[$];

    int  n_pass  = 0;
    int  n_total = 0;
    int  cyc     = 0;
    bit  push_en = 1'b1;

    logic [7:0] px[8];
    logic [7:0] ex[8];

    sensor_noise_filter #(
        .DATA_WIDTH  (DW),
        .CHANNEL_NUM (CH),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_filter_en  (i_filter_en),
        .iv_threshold (iv_threshold),
        .i_fval       (i_fval),
        .i_lval       (i_lval),
        .iv_pix_data  (iv_pix_data),
        .o_fval       (o_fval),
        .o_lval       (o_lval),
        .ov_pix_data  (ov_pix_data),
        .ov_noise_cnt (ov_noise_cnt),
        .o_cnt_valid  (o_cnt_valid)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Driver: one bus beat; in-frame beats queue their expected output
    task automatic beat(input logic f, input logic l, input logic [PW-1:0] d, input logic [PW-1:0] e);
        @(posedge clk);
        #1;
        i_fval      = f;
        i_lval      = l;
        iv_pix_data = d;
        if (push_en && f) begin
            exp_q.push_back({l, e});
            exp_cyc_q.push_back(cyc + 2);
        end
    endtask

    // One line of n beats followed by a single lval-low beat
    task automatic send_line(input int n, input logic [7:0] p[8], input logic [7:0] e[8], input bit all_ch);
        for (int i = 0; i < n; i++) begin
            beat(1'b1, 1'b1,
                 all_ch ? {4{p[i]}} : {24'd0, p[i]},
                 all_ch ? {4{e[i]}} : {24'd0, e[i]});
        end
        beat(1'b1, 1'b0, '0, '0);
    endtask

    // Drop fval and queue the frame's expected correction count
    task automatic frame_end(input logic [CW-1:0] exp_cnt);
        beat(1'b0, 1'b0, '0, '0);
`ifdef NOISE_FILTER_STAT_EN
        if (push_en) begin
            cnt_q.push_back(exp_cnt);
            cnt_cyc_q.push_back(cyc + 2);
        end
`else
        if (exp_cnt != exp_cnt) $display("unreachable");
`endif
        repeat (3) beat(1'b0, 1'b0, '0, '0);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [W-1:0]  e;
        logic [CW-1:0] ce;
        int            c;
        forever begin
            @(negedge clk);
            if (o_fval === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat: got lval=%0b data=%0h at cycle %0d, required no output",
                             o_lval, ov_pix_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("beat_data", {o_lval, ov_pix_data}, e);
                    check("beat_cycle", cyc, c);
                end
            end
            if (o_cnt_valid === 1'b1) begin
                if (cnt_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_cnt_valid: got cnt=%0d at cycle %0d, required no pulse",
                             ov_noise_cnt, cyc);
                end else begin
                    ce = cnt_q.pop_front();
                    c  = cnt_cyc_q.pop_front();
                    check("noise_cnt", ov_noise_cnt, ce);
                    check("cnt_cycle", cyc, c);
                end
            end
        end
    end

    // Stimulus
    initial begin
        reset        = 1'b1;
        i_filter_en  = 1'b1;
        iv_threshold = 8'd0;
        i_fval       = 1'b0;
        i_lval       = 1'b0;
        iv_pix_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fval", o_fval, 0);
        check("rst_lval", o_lval, 0);
        check("rst_data", ov_pix_data, 0);
        check("rst_cnt", ov_noise_cnt, 0);
        check("rst_cnt_valid", o_cnt_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) beat(1'b0, 1'b0, '0, '0);

        // Ramp pass-through
        iv_threshold = 8'd5;
        beat(1'b1, 1'b0, '0, '0);
        px = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd0, 8'd0, 8'd0};
        send_line(5, px, px, 1'b0);
        frame_end(4'd0);

        // High impulse
        iv_threshold = 8'd20;
        beat(1'b1, 1'b0, '0, '0);
        px = '{8'd100, 8'd100, 8'd250, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0};
        ex = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0};
        send_line(5, px, ex, 1'b0);
        frame_end(4'd1);

        // Low impulse, then a deviation equal to the threshold
        beat(1'b1, 1'b0, '0, '0);
        px = '{8'd200, 8'd200, 8'd10, 8'd190, 8'd200, 8'd0, 8'd0, 8'd0};
        ex = '{8'd200, 8'd200, 8'd195, 8'd190, 8'd200, 8'd0, 8'd0, 8'd0};
        send_line(5, px, ex, 1'b0);
        px = '{8'd100, 8'd100, 8'd120, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0};
        send_line(4, px, px, 1'b0);
        frame_end(4'd1);

        // Line edges and a 2-beat line
        beat(1'b1, 1'b0, '0, '0);
        px = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_line(3, px, px, 1'b0);
        px = '{8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_line(3, px, px, 1'b0);
        px = '{8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_line(2, px, px, 1'b0);
        frame_end(4'd0);

        // All channels, 20 corrections: counter saturates at 15
        beat(1'b1, 1'b0, '0, '0);
        px = '{8'd100, 8'd250, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        ex = '{8'd100, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 5; i++) send_line(3, px, ex, 1'b1);
        frame_end(4'd15);

        // Same input with filtering disabled
        i_filter_en = 1'b0;
        beat(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) send_line(3, px, px, 1'b1);
        frame_end(4'd0);
        i_filter_en = 1'b1;

        // Reset in the middle of frame 1: nothing of it may appear
        push_en = 1'b0;
        beat(1'b1, 1'b1, {4{8'd100}}, '0);
        reset = 1'b1;
        beat(1'b1, 1'b1, {4{8'd100}}, '0);
        beat(1'b1, 1'b1, {4{8'd250}}, '0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 1'b1, (i == 1) ? {4{8'd250}} : {4{8'd100}}, '0);
            @(negedge clk);
            check("gated_lval", o_lval, 0);
            check("gated_data", ov_pix_data, 0);
        end
        beat(1'b1, 1'b0, '0, '0);
        frame_end(4'd0);
        push_en = 1'b1;

        // Frame 2 after the reset: fully emitted and filtered
        beat(1'b1, 1'b0, '0, '0);
        px = '{8'd100, 8'd100, 8'd250, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0};
        ex = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0};
        send_line(5, px, ex, 1'b0);
        frame_end(4'd1);

        // Drain with a bounded wait
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && cnt_q.size() == 0) break;
            @(negedge clk);
        end
        check("beat_queue_empty", exp_q.size(), 0);
        check("cnt_queue_empty", cnt_q.size(), 0);
`ifndef NOISE_FILTER_STAT_EN
        check("stat_disabled_cnt", ov_noise_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
